polygon_vertex_buffer: RTL

POLYGON_VERTEX_BUFFER -- requirements
Module: polygon_vertex_buffer

---
 rtl/poly_pkg.sv | 17 +
 rtl/poly_bbox_acc.sv | 43 ++++
 rtl/polygon_vertex_buffer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/poly_pkg.sv
// Shared types and default sizes for the polygon vertex double buffer.
package poly_pkg;

  localparam int MAX_NUM_VERTICES = 32;
  localparam int COORD_WIDTH      = 32;

  typedef struct packed {
    logic signed [COORD_WIDTH-1:0] x;
    logic signed [COORD_WIDTH-1:0] y;
  } vertex_t;

  typedef enum logic {
    LOAD      = 1'b0,
    WAIT_SWAP = 1'b1
  } state_t;

endpackage

// File: rtl/poly_bbox_acc.sv
// Running min/max of the vertices written into the shadow bank.
// The first vertex after a clear seeds all four extremes.
module poly_bbox_acc #(
  parameter int COORD_WIDTH = poly_pkg::COORD_WIDTH
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          clear,
  input  logic                          en,
  input  logic signed [COORD_WIDTH-1:0] x,
  input  logic signed [COORD_WIDTH-1:0] y,
  output logic signed [COORD_WIDTH-1:0] xmin,
  output logic signed [COORD_WIDTH-1:0] xmax,
  output logic signed [COORD_WIDTH-1:0] ymin,
  output logic signed [COORD_WIDTH-1:0] ymax
);
  import poly_pkg::*;

  logic empty;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      empty <= 1'b1;
      xmin  <= '0;
      xmax  <= '0;
      ymin  <= '0;
      ymax  <= '0;
    end else if (clear) begin
      empty <= 1'b1;
      xmin  <= '0;
      xmax  <= '0;
      ymin  <= '0;
      ymax  <= '0;
    end else if (en) begin
      empty <= 1'b0;
      if (empty || x < xmin) xmin <= x;
      if (empty || x > xmax) xmax <= x;
      if (empty || y < ymin) ymin <= y;
      if (empty || y > ymax) ymax <= y;
    end
  end

endmodule

// File: rtl/polygon_vertex_buffer.sv
// Double-buffered polygon vertex store: vertices load into the shadow bank and
// the banks swap at frame start. Define POLY_BBOX_EN to publish a bounding box.
module polygon_vertex_buffer #(
  parameter  int MAX_NUM_VERTICES = poly_pkg::MAX_NUM_VERTICES,
  parameter  int COORD_WIDTH      = poly_pkg::COORD_WIDTH,
  localparam int CNT_W            = $clog2(MAX_NUM_VERTICES + 1)
) (
  input  logic                                         clk_in,
  input  logic                                         rst_n_in,
  input  logic                                         vert_valid_in,
  output logic                                         vert_ready_out,
  input  logic signed [COORD_WIDTH-1:0]                vert_x_in,
  input  logic signed [COORD_WIDTH-1:0]                vert_y_in,
  input  logic                                         vert_last_in,
  input  logic                                         frame_start_in,
  output logic [MAX_NUM_VERTICES-1:0][COORD_WIDTH-1:0] xs_out,
  output logic [MAX_NUM_VERTICES-1:0][COORD_WIDTH-1:0] ys_out,
  output logic [CNT_W-1:0]                             num_points_out,
  output logic                                         pending_out,
  output logic                                         overflow_out,
  output logic                                         degenerate_out,
  output logic signed [COORD_WIDTH-1:0]                bbox_xmin_out,
  output logic signed [COORD_WIDTH-1:0]                bbox_xmax_out,
  output logic signed [COORD_WIDTH-1:0]                bbox_ymin_out,
  output logic signed [COORD_WIDTH-1:0]                bbox_ymax_out
);
  import poly_pkg::*;

  localparam int IDX_W = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;

  state_t                 state, state_next;
  logic                   bank_sel;
  logic [CNT_W-1:0]       count, count_final;
  logic [IDX_W-1:0]       write_idx;
  logic [COORD_WIDTH-1:0] mem_x [2][MAX_NUM_VERTICES];
  logic [COORD_WIDTH-1:0] mem_y [2][MAX_NUM_VERTICES];
  logic accept, room, write_en, last_acc, polygon_done, polygon_drop, do_swap;

  assign accept       = vert_valid_in && vert_ready_out;
  assign room         = (count < CNT_W'(MAX_NUM_VERTICES));
  assign write_en     = accept && room;
  assign write_idx    = count[IDX_W-1:0];
  assign count_final  = write_en ? count + CNT_W'(1) : count;
  assign last_acc     = accept && vert_last_in;
  assign polygon_done = last_acc && (count_final >= CNT_W'(3));
  assign polygon_drop = last_acc && !polygon_done;
  assign do_swap      = (state == WAIT_SWAP) && frame_start_in;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= LOAD;
    else           state <= state_next;
  end

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      LOAD:      if (polygon_done)   state_next = WAIT_SWAP;
      WAIT_SWAP: if (frame_start_in) state_next = LOAD;
      default:                       state_next = LOAD;
    endcase
  end

  always_comb begin
    vert_ready_out = (state == LOAD);
    pending_out    = (state == WAIT_SWAP);
  end

  // A vertex arriving at full capacity is dropped and flagged even when it is
  // the last one; the polygon still completes with the vertices that fit.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bank_sel       <= 1'b0;
      count          <= '0;
      num_points_out <= '0;
      overflow_out   <= 1'b0;
      degenerate_out <= 1'b0;
    end else begin
      if (do_swap) begin
        bank_sel       <= !bank_sel;
        num_points_out <= count;
      end
      if (do_swap || polygon_drop) count <= '0;
      else                         count <= count_final;
      if (accept && !room) overflow_out   <= 1'b1;
      if (polygon_drop)    degenerate_out <= 1'b1;
    end
  end

  // NOTE: the banks drive the outputs directly and must read zero straight out
  // of reset, so the storage is built from resettable flops rather than RAM.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
          mem_x[b][i] <= '0;
          mem_y[b][i] <= '0;
        end
      end
    end else if (write_en) begin
      mem_x[!bank_sel][write_idx] <= vert_x_in;
      mem_y[!bank_sel][write_idx] <= vert_y_in;
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
      xs_out[i] = mem_x[bank_sel][i];
      ys_out[i] = mem_y[bank_sel][i];
    end
  end

`ifdef POLY_BBOX_EN
  logic signed [COORD_WIDTH-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;

  poly_bbox_acc #(
    .COORD_WIDTH (COORD_WIDTH)
  ) u_bbox_acc (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clear    (do_swap || polygon_drop),
    .en       (write_en),
    .x        (vert_x_in),
    .y        (vert_y_in),
    .xmin     (acc_xmin),
    .xmax     (acc_xmax),
    .ymin     (acc_ymin),
    .ymax     (acc_ymax)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bbox_xmin_out <= '0;
      bbox_xmax_out <= '0;
      bbox_ymin_out <= '0;
      bbox_ymax_out <= '0;
    end else if (do_swap) begin
      bbox_xmin_out <= acc_xmin;
      bbox_xmax_out <= acc_xmax;
      bbox_ymin_out <= acc_ymin;
      bbox_ymax_out <= acc_ymax;
    end
  end
`else
  assign bbox_xmin_out = '0;
  assign bbox_xmax_out = '0;
  assign bbox_ymin_out = '0;
  assign bbox_ymax_out = '0;
`endif

endmodule
